// File: rtl/tlb_op_unit.sv
// rtl/tlb_op_unit.sv - joint TLB executing CP0 TLBR/TLBWI/TLBWR/TLBP plus a registered MMU lookup port
//
// Optional build macro: TLB_PROBE_EARLY_EXIT_EN
//   defined   : TLBP stops after the first chunk that contains a match
//   undefined : TLBP always scans every chunk (fixed latency)
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   op_valid, op, op_done       CP0 operation handshake (0=TLBR 1=TLBWI 2=TLBWR 3=TLBP)
//   w_*                         CP0 register snapshot consumed on accept
//   r_*                         TLBR/TLBP results, stable from op_done until the next op_done
//   lookup_vaddr, lookup_asid   MMU translation request (sampled every cycle)
//   lookup_hit/paddr/v/d/c      registered translation result, one cycle after the request
module tlb_op_unit #(
    parameter int INDEX_WIDTH     = 5,
    parameter int TLB_SIZE        = 2**INDEX_WIDTH,
    parameter int PROBE_PER_CYCLE = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [1:0]  op,
    output logic        op_done,
    input  logic [31:0] w_index,
    input  logic [31:0] w_random,
    input  logic [31:0] w_entryhi,
    input  logic [31:0] w_pagemask,
    input  logic [31:0] w_entrylo0,
    input  logic [31:0] w_entrylo1,
    output logic [31:0] r_index,
    output logic [31:0] r_entryhi,
    output logic [31:0] r_pagemask,
    output logic [31:0] r_entrylo0,
    output logic [31:0] r_entrylo1,
    input  logic [31:0] lookup_vaddr,
    input  logic [7:0]  lookup_asid,
    output logic        lookup_hit,
    output logic [31:0] lookup_paddr,
    output logic        lookup_v,
    output logic        lookup_d,
    output logic [2:0]  lookup_c
);

    localparam int NUM_CHUNKS = TLB_SIZE / PROBE_PER_CYCLE;
    localparam int CHUNK_W    = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    localparam logic [1:0] OP_TLBR  = 2'd0;
    localparam logic [1:0] OP_TLBWR = 2'd2;
    localparam logic [1:0] OP_TLBP  = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_PROBE, S_DONE, S_HOLD} state_t;

    state_t state, state_nxt;

    // Half-page entry words hold EntryLo[25:1]: {PFN, C, D, V}. G is kept separately.
    logic [18:0] e_vpn2 [TLB_SIZE];
    logic [7:0]  e_asid [TLB_SIZE];
    logic        e_g    [TLB_SIZE];
    logic [24:0] e_lo0  [TLB_SIZE];
    logic [24:0] e_lo1  [TLB_SIZE];

    // Snapshot of the request, taken on the accept edge
    logic [1:0]             op_q;
    logic [INDEX_WIDTH-1:0] idx_q;
    logic [INDEX_WIDTH-1:0] rnd_q;
    logic [18:0]            vpn2_q;
    logic [7:0]             asid_q;
    logic [25:0]            lo0_q;
    logic [25:0]            lo1_q;

    // Probe progress
    logic [CHUNK_W-1:0]     chunk_cnt;
    logic                   found_q;
    logic [INDEX_WIDTH-1:0] found_idx;
    logic                   chunk_hit;
    logic [INDEX_WIDTH-1:0] chunk_idx;
    logic [INDEX_WIDTH-1:0] pidx;
    logic                   last_chunk;
    logic                   probe_exit;
    logic [31:0]            probe_result;

    logic [INDEX_WIDTH-1:0] wr_idx;

    // Lookup compare
    logic                   lk_hit;
    logic [INDEX_WIDTH-1:0] lk_sel;
    logic [INDEX_WIDTH-1:0] lk_i;
    logic [24:0]            lk_half;

    assign r_pagemask = '0;
    assign wr_idx     = (op_q == OP_TLBWR) ? rnd_q : idx_q;
    assign last_chunk = (chunk_cnt == CHUNK_W'(NUM_CHUNKS - 1));

`ifdef TLB_PROBE_EARLY_EXIT_EN
    assign probe_exit = last_chunk || chunk_hit;
`else
    assign probe_exit = last_chunk;
`endif

    // Lowest matching entry within the current chunk; descending scan so the lowest wins.
    always_comb begin
        chunk_hit = 1'b0;
        chunk_idx = '0;
        pidx      = '0;
        for (int j = PROBE_PER_CYCLE - 1; j >= 0; j--) begin
            pidx = INDEX_WIDTH'(int'(chunk_cnt) * PROBE_PER_CYCLE + j);
            if (e_vpn2[pidx] == vpn2_q && (e_g[pidx] || e_asid[pidx] == asid_q)) begin
                chunk_hit = 1'b1;
                chunk_idx = pidx;
            end
        end
    end

    // A match from an earlier chunk always beats the current one.
    always_comb begin
        probe_result = 32'h8000_0000;
        if (found_q) begin
            probe_result = {{(32-INDEX_WIDTH){1'b0}}, found_idx};
        end else if (chunk_hit) begin
            probe_result = {{(32-INDEX_WIDTH){1'b0}}, chunk_idx};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        op_done   = 1'b0;
        case (state)
            S_IDLE: begin
                if (op_valid) begin
                    state_nxt = (op == OP_TLBP) ? S_PROBE : S_EXEC;
                end
            end
            S_EXEC:  state_nxt = S_DONE;
            S_PROBE: begin
                if (probe_exit) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                op_done   = 1'b1;
                state_nxt = S_HOLD;
            end
            S_HOLD: begin
                // Wait for the requester to drop op_valid so a held request is not re-run
                if (!op_valid) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TLB_SIZE; i++) begin
                e_vpn2[INDEX_WIDTH'(i)] <= '0;
                e_asid[INDEX_WIDTH'(i)] <= '0;
                e_g[INDEX_WIDTH'(i)]    <= 1'b0;
                e_lo0[INDEX_WIDTH'(i)]  <= '0;
                e_lo1[INDEX_WIDTH'(i)]  <= '0;
            end
            op_q       <= '0;
            idx_q      <= '0;
            rnd_q      <= '0;
            vpn2_q     <= '0;
            asid_q     <= '0;
            lo0_q      <= '0;
            lo1_q      <= '0;
            chunk_cnt  <= '0;
            found_q    <= 1'b0;
            found_idx  <= '0;
            r_index    <= '0;
            r_entryhi  <= '0;
            r_entrylo0 <= '0;
            r_entrylo1 <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (op_valid) begin
                        op_q      <= op;
                        idx_q     <= w_index[INDEX_WIDTH-1:0];
                        rnd_q     <= w_random[INDEX_WIDTH-1:0];
                        vpn2_q    <= w_entryhi[31:13];
                        asid_q    <= w_entryhi[7:0];
                        lo0_q     <= w_entrylo0[25:0];
                        lo1_q     <= w_entrylo1[25:0];
                        chunk_cnt <= '0;
                        found_q   <= 1'b0;
                        found_idx <= '0;
                    end
                end
                S_EXEC: begin
                    if (op_q == OP_TLBR) begin
                        r_entryhi  <= {e_vpn2[idx_q], 5'b0, e_asid[idx_q]};
                        r_entrylo0 <= {6'b0, e_lo0[idx_q], e_g[idx_q]};
                        r_entrylo1 <= {6'b0, e_lo1[idx_q], e_g[idx_q]};
                    end else begin
                        e_vpn2[wr_idx] <= vpn2_q;
                        e_asid[wr_idx] <= asid_q;
                        e_g[wr_idx]    <= lo0_q[0] & lo1_q[0];
                        e_lo0[wr_idx]  <= lo0_q[25:1];
                        e_lo1[wr_idx]  <= lo1_q[25:1];
                    end
                end
                S_PROBE: begin
                    chunk_cnt <= chunk_cnt + CHUNK_W'(1);
                    if (!found_q && chunk_hit) begin
                        found_q   <= 1'b1;
                        found_idx <= chunk_idx;
                    end
                    if (probe_exit) begin
                        r_index <= probe_result;
                    end
                end
                default: ;
            endcase
        end
    end

    // Fully associative lookup; descending scan so the lowest matching index wins.
    always_comb begin
        lk_hit = 1'b0;
        lk_sel = '0;
        lk_i   = '0;
        for (int i = TLB_SIZE - 1; i >= 0; i--) begin
            lk_i = INDEX_WIDTH'(i);
            if (e_vpn2[lk_i] == lookup_vaddr[31:13] &&
                (e_g[lk_i] || e_asid[lk_i] == lookup_asid)) begin
                lk_hit = 1'b1;
                lk_sel = lk_i;
            end
        end
    end

    assign lk_half = lookup_vaddr[12] ? e_lo1[lk_sel] : e_lo0[lk_sel];

    always_ff @(posedge clk) begin
        if (rst || !lk_hit) begin
            lookup_hit   <= 1'b0;
            lookup_paddr <= '0;
            lookup_v     <= 1'b0;
            lookup_d     <= 1'b0;
            lookup_c     <= '0;
        end else begin
            lookup_hit   <= 1'b1;
            lookup_paddr <= {lk_half[24:5], lookup_vaddr[11:0]};
            lookup_v     <= lk_half[0];
            lookup_d     <= lk_half[1];
            lookup_c     <= lk_half[4:2];
        end
    end

endmodule
